fetch_unit: RTL

- Instruction fetch stage that sits directly upstream of the opcode decoder.
- Holds the PC and issues word fetches to instruction memory.
- Buffers returned words in a small FIFO and presents them, with their PC, to decode under a valid/ready handshake.
- Handles redirects from branch resolution (B, BEQ, JMP/FUN, RET/INTR targets): flushes the queue and drops stale in-flight responses.

---
 rtl/fetch_unit.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word fetch at a time to
// instruction memory, queues returned words with their PC and hands them to
// the decoder under a valid/ready handshake. Redirects flush the queue and
// cause the in-flight response (if any) to be discarded.
// Optional build macro FETCH_STATS_EN adds stat_fetched / stat_flushed
// saturating counters; without it the block has no statistics ports.
module fetch_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [4:0]  if_opcode,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    input  logic        id_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_flushed
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t          r_state;
    logic [31:0]     r_pc;
    logic [31:0]     r_req_pc;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [31:0]     r_instr_q [DEPTH];
    logic [31:0]     r_pc_q    [DEPTH];

    logic            w_issue;
    logic            w_push;
    logic            w_pop;
    logic [31:0]     w_redirect_pc;
    logic [31:0]     w_head_pc;

    // A slot is reserved at issue time: only request while the queue has room,
    // and never in the cycle a redirect is being applied or during reset.
    assign imem_req      = !rst && (r_state == S_REQ) && (r_count < DEPTH_C) && !redirect_valid;
    assign imem_addr     = r_pc;
    assign w_issue       = imem_req && imem_gnt;
    assign w_push        = (r_state == S_WAIT) && imem_rvalid && !redirect_valid;
    assign w_pop         = if_valid && id_ready && !redirect_valid;
    assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;

    assign if_valid    = (r_count != {CW{1'b0}});
    assign w_head_pc   = r_pc_q[r_rd_ptr];
    assign if_instr    = if_valid ? r_instr_q[r_rd_ptr] : 32'd0;
    assign if_opcode   = if_instr[31:27];
    assign if_pc       = if_valid ? w_head_pc : 32'd0;
    assign if_pc_plus4 = if_valid ? (w_head_pc + 32'd4) : 32'd0;

    // Fetch FSM and PC: issue, wait for the response, or wait to discard a stale one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_REQ;
            r_pc     <= RESET_PC;
            r_req_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= w_redirect_pc;
            case (r_state)
                // An outstanding response becomes stale; if it is arriving right
                // now it is simply dropped and nothing is left in flight.
                S_WAIT:    r_state <= imem_rvalid ? S_REQ : S_DISCARD;
                S_DISCARD: r_state <= imem_rvalid ? S_REQ : S_DISCARD;
                default:   r_state <= S_REQ;
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_issue) begin
                        r_req_pc <= r_pc;
                        r_pc     <= r_pc + 32'd4;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        r_state <= S_REQ;
                    end
                end
                S_DISCARD: begin
                    if (imem_rvalid) begin
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

    // Instruction queue: push returned words, pop on decode handshake, flush on redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= {CW{1'b0}};
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_instr_q[i] <= 32'd0;
                r_pc_q[i]    <= 32'd0;
            end
        end else if (redirect_valid) begin
            r_count  <= {CW{1'b0}};
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
        end else begin
            if (w_push) begin
                r_instr_q[r_wr_ptr] <= imem_rdata;
                r_pc_q[r_wr_ptr]    <= r_req_pc;
                r_wr_ptr            <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{(CW-1){1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] r_stat_fetched;
    logic [31:0] r_stat_flushed;
    logic [31:0] w_flush_amt;
    logic [32:0] w_fetched_sum;
    logic [32:0] w_flushed_sum;

    // A response is counted as dropped at the redirect that makes it stale,
    // i.e. when the redirect catches the FSM waiting on memory.
    assign w_flush_amt   = {{(32-CW){1'b0}}, r_count} + ((r_state == S_WAIT) ? 32'd1 : 32'd0);
    assign w_fetched_sum = {1'b0, r_stat_fetched} + 33'd1;
    assign w_flushed_sum = {1'b0, r_stat_flushed} + {1'b0, w_flush_amt};

    // Saturating fetch / flush statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_fetched <= 32'd0;
            r_stat_flushed <= 32'd0;
        end else begin
            if (w_push) begin
                r_stat_fetched <= w_fetched_sum[32] ? 32'hFFFF_FFFF : w_fetched_sum[31:0];
            end
            if (redirect_valid) begin
                r_stat_flushed <= w_flushed_sum[32] ? 32'hFFFF_FFFF : w_flushed_sum[31:0];
            end
        end
    end

    assign stat_fetched = r_stat_fetched;
    assign stat_flushed = r_stat_flushed;
`endif

endmodule
